redas_array_ctrl_sequencer: RTL and testbench

- Drives the per-PE control inputs of a roundabout ReDAS array for one tile operation: data_movement_mode, calculation_pattern_mode, enable_right_angle_movement and store_stationary.
- Accepts a tile command (dataflow + reduction length) over a valid/ready handshake, sequences CONFIG, PRELOAD, COMPUTE and DRAIN phases with cycle counters, and tells the edge feeders and drainers when to move data.
- Sits between the tile scheduler and the array; its control outputs are broadcast unchanged to every PE.

---
 rtl/redas_array_ctrl_sequencer_pkg.sv | 68 ++++++
 rtl/redas_array_ctrl_sequencer_if.sv | 23 ++
 rtl/redas_array_ctrl_sequencer_phase_counter.sv | 26 ++
 rtl/redas_array_ctrl_sequencer.sv | 165 ++++++++++++++++
 tb/tb_redas_array_ctrl_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/redas_array_ctrl_sequencer_pkg.sv
// Shared types and per-dataflow control-word table for the ReDAS array control sequencer.
package redas_ctrl_pkg;

    typedef enum logic [1:0] {
        DF_WEIGHT = 2'd0,
        DF_OUTPUT = 2'd1,
        DF_INPUT  = 2'd2
    } dataflow_e;

    localparam logic [1:0] DF_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_PRELOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [3:0] dm;
        logic [4:0] cp;
        logic       ram;
        logic       ss;
    } ctrl_word_t;

    typedef struct packed {
        logic [3:0] dm;
        logic       ram;
        logic [4:0] cp_preload;
        logic [4:0] cp_compute;
        logic [4:0] cp_drain;
    } df_entry_t;

    localparam ctrl_word_t CTRL_RESET = '{dm: 4'b1111, cp: 5'b11000, ram: 1'b0, ss: 1'b0};

    function automatic df_entry_t df_entry(input dataflow_e df);
        df_entry_t e;
        case (df)
            DF_OUTPUT: e = '{dm: 4'b1111, ram: 1'b1, cp_preload: 5'b11000,
                             cp_compute: 5'b11011, cp_drain: 5'b00110};
            DF_INPUT:  e = '{dm: 4'b1100, ram: 1'b0, cp_preload: 5'b11011,
                             cp_compute: 5'b00001, cp_drain: 5'b11000};
            default:   e = '{dm: 4'b1111, ram: 1'b0, cp_preload: 5'b11011,
                             cp_compute: 5'b00001, cp_drain: 5'b11000};
        endcase
        return e;
    endfunction

    // CONFIG already presents the compute pattern so the PE crossbars settle early.
    function automatic ctrl_word_t get_ctrl_word(input dataflow_e df, input state_e st);
        df_entry_t  e;
        ctrl_word_t w;
        e = df_entry(df);
        w = CTRL_RESET;
        case (st)
            ST_CONFIG:  w = '{dm: e.dm, cp: e.cp_compute, ram: e.ram, ss: 1'b0};
            ST_PRELOAD: w = '{dm: e.dm, cp: e.cp_preload, ram: e.ram, ss: 1'b1};
            ST_COMPUTE: w = '{dm: e.dm, cp: e.cp_compute, ram: e.ram, ss: (df == DF_OUTPUT)};
            ST_DRAIN:   w = '{dm: e.dm, cp: e.cp_drain,   ram: e.ram, ss: 1'b0};
            ST_DONE:    w = '{dm: e.dm, cp: e.cp_drain,   ram: e.ram, ss: 1'b0};
            default:    w = CTRL_RESET;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/redas_array_ctrl_sequencer_if.sv
// Tile command handshake between the tile scheduler (master) and the sequencer (slave).
interface redas_array_ctrl_sequencer_if #(
    parameter int LEN_WIDTH = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_dataflow;
    logic [LEN_WIDTH-1:0] cmd_k_len;

    modport master (
        output cmd_valid,
        output cmd_dataflow,
        output cmd_k_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dataflow,
        input  cmd_k_len,
        output cmd_ready
    );
endinterface

// File: rtl/redas_array_ctrl_sequencer_phase_counter.sv
// Down-counter timing each sequencer phase; loaded with length-1 and stops at zero.
module redas_phase_counter #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 dec,
    input  logic [LEN_WIDTH-1:0] load_value,
    output logic [LEN_WIDTH-1:0] count,
    output logic                 zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - LEN_WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/redas_array_ctrl_sequencer.sv
// Sequences CONFIG/PRELOAD/COMPUTE/DRAIN for one ReDAS tile and broadcasts the PE control word.
module redas_array_ctrl_sequencer
    import redas_ctrl_pkg::*;
#(
    parameter int ARRAY_ROWS = 4,
    parameter int ARRAY_COLS = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    redas_array_ctrl_sequencer_if.slave cmd_bus,
    input  logic       abort,
    output logic [3:0] pe_data_movement_mode,
    output logic [4:0] pe_calculation_pattern_mode,
    output logic       pe_enable_right_angle_movement,
    output logic       pe_store_stationary,
    output logic       feed_preload,
    output logic       feed_stream,
    output logic       drain_en,
    output logic       busy,
    output logic       done,
    output logic       cmd_err
);

    localparam int EXT_WIDTH = LEN_WIDTH + 2;
    localparam logic [LEN_WIDTH-1:0] PRELOAD_LOAD = LEN_WIDTH'(ARRAY_ROWS - 1);
    localparam logic [LEN_WIDTH-1:0] DRAIN_LOAD   = LEN_WIDTH'(ARRAY_ROWS + ARRAY_COLS - 2);
    localparam logic [LEN_WIDTH-1:0] STREAM_MIN   = LEN_WIDTH'(ARRAY_ROWS + ARRAY_COLS - 2);
    localparam logic [EXT_WIDTH-1:0] SKEW_M1      = EXT_WIDTH'(ARRAY_ROWS + ARRAY_COLS - 3);

    state_e               state, state_next;
    dataflow_e            df_reg, df_next;
    logic [LEN_WIDTH-1:0] k_reg, k_eff;
    logic [EXT_WIDTH-1:0] compute_len_m1;
    logic [LEN_WIDTH-1:0] compute_load;
    logic [LEN_WIDTH-1:0] cnt, cnt_next, cnt_load_value;
    logic                 cnt_zero, cnt_load, cnt_dec;
    logic                 accept_legal, err_next;
    ctrl_word_t           word_next;

    assign cmd_bus.cmd_ready = (state == ST_IDLE);
    assign k_eff             = (cmd_bus.cmd_k_len == '0) ? LEN_WIDTH'(1) : cmd_bus.cmd_k_len;

    // COMPUTE length is K plus the skew fill; saturate if it cannot fit the counter.
    assign compute_len_m1 = {2'b00, k_reg} + SKEW_M1;
    assign compute_load   = (|compute_len_m1[EXT_WIDTH-1:LEN_WIDTH]) ? '1
                                                                      : compute_len_m1[LEN_WIDTH-1:0];

    redas_phase_counter #(.LEN_WIDTH(LEN_WIDTH)) u_phase_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (cnt_load_value),
        .count      (cnt),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_next     = state;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        cnt_dec        = 1'b0;
        accept_legal   = 1'b0;
        err_next       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_bus.cmd_valid) begin
                    if (cmd_bus.cmd_dataflow == DF_ILLEGAL) begin
                        err_next = 1'b1;
                    end else begin
                        accept_legal = 1'b1;
                        state_next   = ST_CONFIG;
                        cnt_load     = 1'b1;
                    end
                end
            end
            ST_CONFIG: begin
                cnt_load = 1'b1;
                if (df_reg == DF_OUTPUT) begin
                    state_next     = ST_COMPUTE;
                    cnt_load_value = compute_load;
                end else begin
                    state_next     = ST_PRELOAD;
                    cnt_load_value = PRELOAD_LOAD;
                end
            end
            ST_PRELOAD: begin
                if (cnt_zero) begin
                    state_next     = ST_COMPUTE;
                    cnt_load       = 1'b1;
                    cnt_load_value = compute_load;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_COMPUTE: begin
                if (cnt_zero) begin
                    state_next     = ST_DRAIN;
                    cnt_load       = 1'b1;
                    cnt_load_value = DRAIN_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_zero) begin
                    state_next = ST_DONE;
                    cnt_load   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_load   = 1'b1;
            end
        endcase
        if (abort && (state != ST_IDLE)) begin
            state_next     = ST_IDLE;
            cnt_load       = 1'b1;
            cnt_load_value = '0;
            cnt_dec        = 1'b0;
        end
        cnt_next  = cnt_load ? cnt_load_value : (cnt_dec ? (cnt - LEN_WIDTH'(1)) : cnt);
        df_next   = accept_legal ? dataflow_e'(cmd_bus.cmd_dataflow) : df_reg;
        word_next = get_ctrl_word(df_next, state_next);
    end

    // Outputs are registered from the next state so they line up with the phase they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                          <= ST_IDLE;
            df_reg                         <= DF_WEIGHT;
            k_reg                          <= LEN_WIDTH'(1);
            pe_data_movement_mode          <= CTRL_RESET.dm;
            pe_calculation_pattern_mode    <= CTRL_RESET.cp;
            pe_enable_right_angle_movement <= CTRL_RESET.ram;
            pe_store_stationary            <= CTRL_RESET.ss;
            feed_preload                   <= 1'b0;
            feed_stream                    <= 1'b0;
            drain_en                       <= 1'b0;
            busy                           <= 1'b0;
            done                           <= 1'b0;
            cmd_err                        <= 1'b0;
        end else begin
            state <= state_next;
            if (accept_legal) begin
                df_reg <= dataflow_e'(cmd_bus.cmd_dataflow);
                k_reg  <= k_eff;
            end
            pe_data_movement_mode          <= word_next.dm;
            pe_calculation_pattern_mode    <= word_next.cp;
            pe_enable_right_angle_movement <= word_next.ram;
            pe_store_stationary            <= word_next.ss;
            feed_preload                   <= (state_next == ST_PRELOAD);
            feed_stream                    <= (state_next == ST_COMPUTE) && (cnt_next >= STREAM_MIN);
            drain_en                       <= (state_next == ST_DRAIN);
            busy                           <= (state_next != ST_IDLE);
            done                           <= (state_next == ST_DONE);
            cmd_err                        <= err_next;
        end
    end

endmodule

// File: tb/tb_redas_array_ctrl_sequencer.sv
// Directed self-checking bench: per-cycle comparison of all outputs against a phase-schedule model.
module tb_redas_array_ctrl_sequencer;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic       clk;
    logic       rst_n;
    logic       abort;
    logic [3:0] pe_dm;
    logic [4:0] pe_cp;
    logic       pe_ram;
    logic       pe_ss;
    logic       feed_preload;
    logic       feed_stream;
    logic       drain_en;
    logic       busy;
    logic       done;
    logic       cmd_err;

    int pass_count  = 0;
    int check_count = 0;

    redas_array_ctrl_sequencer_if #(.LEN_WIDTH(16)) cmd_bus ();

    redas_array_ctrl_sequencer #(
        .ARRAY_ROWS (ROWS),
        .ARRAY_COLS (COLS),
        .LEN_WIDTH  (16)
    ) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .cmd_bus                        (cmd_bus),
        .abort                          (abort),
        .pe_data_movement_mode          (pe_dm),
        .pe_calculation_pattern_mode    (pe_cp),
        .pe_enable_right_angle_movement (pe_ram),
        .pe_store_stationary            (pe_ss),
        .feed_preload                   (feed_preload),
        .feed_stream                    (feed_stream),
        .drain_en                       (drain_en),
        .busy                           (busy),
        .done                           (done),
        .cmd_err                        (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Vector layout: {dm, cp, ram, ss, feed_preload, feed_stream, drain_en, busy, done, cmd_err, cmd_ready}
    function automatic logic [17:0] pack(input logic [3:0] dm, input logic [4:0] cp, input logic ram,
                                         input logic ss, input logic fp, input logic fs, input logic de,
                                         input logic bsy, input logic dn, input logic err, input logic rdy);
        return {dm, cp, ram, ss, fp, fs, de, bsy, dn, err, rdy};
    endfunction

    function automatic logic [17:0] idle_vec(input logic err);
        return pack(4'b1111, 5'b11000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err, 1'b1);
    endfunction

    function automatic int tile_len(input int df, input int k);
        int keff;
        keff = (k == 0) ? 1 : k;
        return 1 + ((df == 1) ? 0 : ROWS) + (keff + ROWS + COLS - 2) + (ROWS + COLS - 1);
    endfunction

    // Cycle n is sampled just after the n-th edge, counting the accept edge as 1.
    function automatic logic [17:0] model_vec(input int df, input int k, input int n);
        int         keff, pre, comp, drn, j;
        logic [3:0] dm;
        logic [4:0] cpc, cpd;
        logic       ram;
        if (df == 3) return idle_vec(n == 1);
        keff = (k == 0) ? 1 : k;
        pre  = (df == 1) ? 0 : ROWS;
        comp = keff + ROWS + COLS - 2;
        drn  = ROWS + COLS - 1;
        dm   = (df == 2) ? 4'b1100 : 4'b1111;
        ram  = (df == 1);
        cpc  = (df == 1) ? 5'b11011 : 5'b00001;
        cpd  = (df == 1) ? 5'b00110 : 5'b11000;
        if (n == 1) return pack(dm, cpc, ram, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        if (n <= 1 + pre) return pack(dm, 5'b11011, ram, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        if (n <= 1 + pre + comp) begin
            j = n - 2 - pre;
            return pack(dm, cpc, ram, (df == 1), 1'b0, (j < keff), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        if (n <= 1 + pre + comp + drn) return pack(dm, cpd, ram, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        if (n == 2 + pre + comp + drn) return pack(4'b0000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        return idle_vec(1'b0);
    endfunction

    // The control word shown during the single DONE cycle is not checked, only the flags.
    function automatic logic [17:0] model_mask(input int df, input int k, input int n);
        if (df != 3 && n == tile_len(df, k) + 1) return 18'h0007F;
        return 18'h3FFFF;
    endfunction

    function automatic logic [17:0] dut_vec();
        return pack(pe_dm, pe_cp, pe_ram, pe_ss, feed_preload, feed_stream, drain_en,
                    busy, done, cmd_err, cmd_bus.cmd_ready);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] df, input logic [15:0] k);
        cmd_bus.cmd_valid    = 1'b1;
        cmd_bus.cmd_dataflow = df;
        cmd_bus.cmd_k_len    = k;
        tick();
        cmd_bus.cmd_valid    = 1'b0;
        cmd_bus.cmd_dataflow = 2'd0;
        cmd_bus.cmd_k_len    = 16'd0;
    endtask

    // Starts at cycle 1 of a tile; stop_at == 0 runs through DONE and one idle cycle.
    task automatic checkTile(input string name, input int df, input int k, input int stop_at);
        int          last, first_done, done_pulses;
        logic [17:0] act, mask;
        last        = (df == 3) ? 2 : tile_len(df, k) + 2;
        first_done  = 0;
        done_pulses = 0;
        if (stop_at != 0) last = stop_at;
        for (int n = 1; n <= last; n++) begin
            if (n > 1) tick();
            act  = dut_vec();
            mask = model_mask(df, k, n);
            checkOutput($sformatf("%s cycle%0d", name, n), 32'(act & mask), 32'(model_vec(df, k, n) & mask));
            if (done) begin
                done_pulses++;
                if (first_done == 0) first_done = n;
            end
        end
        if (stop_at == 0 && df != 3) begin
            checkOutput($sformatf("%s done_latency", name), 32'(first_done), 32'(tile_len(df, k) + 1));
            checkOutput($sformatf("%s done_pulses", name), 32'(done_pulses), 32'd1);
        end
    endtask

    initial begin
        rst_n                = 1'b0;
        abort                = 1'b0;
        cmd_bus.cmd_valid    = 1'b0;
        cmd_bus.cmd_dataflow = 2'd0;
        cmd_bus.cmd_k_len    = 16'd0;
        tick();
        tick();
        checkOutput("reset_state", 32'(dut_vec()), 32'(idle_vec(1'b0)));
        rst_n = 1'b1;
        tick();
        checkOutput("idle_after_reset", 32'(dut_vec()), 32'(idle_vec(1'b0)));

        $display("[TB] WEIGHT K=8");
        applyStimulus(2'd0, 16'd8);
        checkTile("weight_k8", 0, 8, 0);

        $display("[TB] OUTPUT K=3");
        applyStimulus(2'd1, 16'd3);
        checkTile("output_k3", 1, 3, 0);

        $display("[TB] illegal dataflow");
        applyStimulus(2'd3, 16'd5);
        checkTile("illegal_df", 3, 5, 0);

        $display("[TB] INPUT K=0");
        applyStimulus(2'd2, 16'd0);
        checkTile("input_k0", 2, 0, 0);

        $display("[TB] abort on third COMPUTE cycle");
        applyStimulus(2'd0, 16'd5);
        checkTile("abort_tile", 0, 5, 1 + ROWS + 3);
        abort                = 1'b1;
        cmd_bus.cmd_valid    = 1'b1;
        cmd_bus.cmd_dataflow = 2'd1;
        cmd_bus.cmd_k_len    = 16'd2;
        tick();
        checkOutput("abort_to_idle", 32'(dut_vec()), 32'(idle_vec(1'b0)));
        abort = 1'b0;
        tick();
        cmd_bus.cmd_valid    = 1'b0;
        cmd_bus.cmd_dataflow = 2'd0;
        cmd_bus.cmd_k_len    = 16'd0;
        checkTile("after_abort", 1, 2, 0);

        $display("[TB] asynchronous reset during DRAIN");
        applyStimulus(2'd0, 16'd2);
        checkTile("reset_tile", 0, 2, 1 + ROWS + (2 + ROWS + COLS - 2) + 3);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 32'(dut_vec()), 32'(idle_vec(1'b0)));
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("idle_after_mid_reset", 32'(dut_vec()), 32'(idle_vec(1'b0)));
        applyStimulus(2'd2, 16'd4);
        checkTile("post_reset_tile", 2, 4, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
